// File: rtl/regfile_param.sv
// -----------------------------------------------------------------------------
// regfile_param -- parametrised general-purpose register file for the decode
// stage. Two asynchronous source read ports, one asynchronous read port at the
// write address, one synchronous write port. Reset and clr start a hardware
// clear sweep that zeroes every register, one register per clock.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> a write in progress is forwarded combinationally to any read
//                port addressing the same register (IDLE only)
//   undefined -> reads always return the pre-edge storage contents
//
// Parameters
//   DATA_W   register width in bits
//   ADDR_W   address width, DEPTH = 2**ADDR_W registers
//   ZERO_REG 1 = register 0 reads 0 and ignores writes, 0 = ordinary register
//
// Ports
//   clock   rising-edge clock for all state
//   reset   synchronous active-high reset, starts a clear sweep
//   clr     request a clear sweep (ignored while busy)
//   wsign   write enable (ignored while busy)
//   waddr   write address, also the rdata3 read address
//   wdata   write data
//   raddr1  read address, port 1
//   raddr2  read address, port 2
//   rdata1  registers[raddr1], combinational, 0 while busy
//   rdata2  registers[raddr2], combinational, 0 while busy
//   rdata3  registers[waddr],  combinational, 0 while busy
//   busy    clear sweep in progress (decoded from the state register)
// -----------------------------------------------------------------------------
module regfile_param #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clr,
    input  logic              wsign,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] rdata3,
    output logic              busy
);

    localparam int unsigned       DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;

    logic [DATA_W-1:0] regs [DEPTH];

    logic              zero_waddr;
    logic              sweep_we;
    logic              wr_en;

    // busy is a pure decode of the one-bit state register, so it cannot glitch
    assign busy = (state == CLEAR);

    // Writes aimed at a hardwired zero register are discarded
    assign zero_waddr = (ZERO_REG != 0) && (waddr == '0);

    // Sweep writes stop while reset is held so storage is left untouched
    assign sweep_we = !reset && (state == CLEAR);

    // clr outranks a same-cycle write; reset drops any write
    assign wr_en = !reset && (state == IDLE) && wsign && !clr && !zero_waddr;

    // Sweep controller: reset or clr restart the sweep at register 0
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    cnt <= cnt + ADDR_W'(1);
                    if (cnt == LAST_IDX) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (clr) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= CLEAR;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Register storage: sweep zeroing or a single functional write per edge
    always_ff @(posedge clock) begin
        if (sweep_we) begin
            regs[cnt] <= '0;
        end else if (wr_en) begin
            regs[waddr] <= wdata;
        end
    end

    // Read ports: storage, optional forwarding, zero register, busy blanking
    always_comb begin
        rdata1 = regs[raddr1];
        rdata2 = regs[raddr2];
        rdata3 = regs[waddr];

`ifdef REGFILE_BYPASS_EN
        // wr_en already excludes busy, clr, reset and the zero register
        if (wr_en) begin
            if (raddr1 == waddr) begin
                rdata1 = wdata;
            end
            if (raddr2 == waddr) begin
                rdata2 = wdata;
            end
            rdata3 = wdata;
        end
`endif

        if (ZERO_REG != 0) begin
            if (raddr1 == '0) begin
                rdata1 = '0;
            end
            if (raddr2 == '0) begin
                rdata2 = '0;
            end
            if (waddr == '0) begin
                rdata3 = '0;
            end
        end

        if (busy) begin
            rdata1 = '0;
            rdata2 = '0;
            rdata3 = '0;
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// -----------------------------------------------------------------------------
// tb_regfile_param -- self-checking bench for regfile_param. Two instances share
// all inputs: dut_a with ZERO_REG=1 and dut_b with ZERO_REG=0. Table vectors are
// driven at the falling edge and their expected pre-edge read values are queued
// and compared before the next rising edge; sweep sequences are hand-written.
// -----------------------------------------------------------------------------
module tb_regfile_param;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    logic              clock;
    logic              reset;
    logic              clr;
    logic              wsign;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;

    logic [DATA_W-1:0] rdata1_a, rdata2_a, rdata3_a;
    logic [DATA_W-1:0] rdata1_b, rdata2_b, rdata3_b;
    logic              busy_a, busy_b;

    int checks   = 0;
    int failures = 0;

    regfile_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut_a (
        .clock(clock), .reset(reset), .clr(clr), .wsign(wsign),
        .waddr(waddr), .wdata(wdata), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1_a), .rdata2(rdata2_a), .rdata3(rdata3_a), .busy(busy_a)
    );

    regfile_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(0)) dut_b (
        .clock(clock), .reset(reset), .clr(clr), .wsign(wsign),
        .waddr(waddr), .wdata(wdata), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1_b), .rdata2(rdata2_b), .rdata3(rdata3_b), .busy(busy_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One vector: inputs plus pre-edge expectations without forwarding
    typedef struct {
        string             name;
        logic              wsign;
        logic              clr;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
        logic [ADDR_W-1:0] raddr1;
        logic [ADDR_W-1:0] raddr2;
        logic [DATA_W-1:0] e1;
        logic [DATA_W-1:0] e2;
        logic [DATA_W-1:0] e3;
        logic [DATA_W-1:0] e1b;
    } vec_t;

    vec_t tbl [$];
    vec_t exp_q [$];

    function automatic vec_t mk(input string name, input logic ws, input logic cl,
                                input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                                input logic [ADDR_W-1:0] ra1, input logic [ADDR_W-1:0] ra2,
                                input logic [DATA_W-1:0] e1, input logic [DATA_W-1:0] e2,
                                input logic [DATA_W-1:0] e3, input logic [DATA_W-1:0] e1b);
        vec_t v;
        v.name = name; v.wsign = ws; v.clr = cl; v.waddr = wa; v.wdata = wd;
        v.raddr1 = ra1; v.raddr2 = ra2; v.e1 = e1; v.e2 = e2; v.e3 = e3; v.e1b = e1b;
        return v;
    endfunction

    // Forwarding rule applied on top of the table values (IDLE vectors only)
    function automatic vec_t expect_of(input vec_t v);
        vec_t e;
        e = v;
`ifdef REGFILE_BYPASS_EN
        if (v.wsign && !v.clr) begin
            if (v.waddr != '0) begin
                if (v.raddr1 == v.waddr) e.e1 = v.wdata;
                if (v.raddr2 == v.waddr) e.e2 = v.wdata;
                e.e3 = v.wdata;
            end
            if (v.raddr1 == v.waddr) e.e1b = v.wdata;
        end
`endif
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive a vector at the falling edge, queue its expectation, compare pre-edge
    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clock);
        wsign = v.wsign; clr = v.clr; waddr = v.waddr; wdata = v.wdata;
        raddr1 = v.raddr1; raddr2 = v.raddr2;
        exp_q.push_back(expect_of(v));
        #2;
        e = exp_q.pop_front();
        chk({e.name, " rdata1"},   rdata1_a, e.e1);
        chk({e.name, " rdata2"},   rdata2_a, e.e2);
        chk({e.name, " rdata3"},   rdata3_a, e.e3);
        chk({e.name, " rdata1_z0"}, rdata1_b, e.e1b);
        chk({e.name, " busy"},     32'(busy_a), 32'd0);
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clock);
        wsign = 1'b1; clr = 1'b0; waddr = a; wdata = d;
    endtask

    // Count busy cycles while hammering wsign and clr; outputs must stay 0
    task automatic sweep_check(input bit wait_first, input string name);
        int n;
        bit bad;
        n = 0;
        bad = 1'b0;
        if (wait_first) @(negedge clock);
        for (int i = 0; i < 100; i++) begin
            wsign = 1'b1; clr = i[0]; waddr = 5'd3; wdata = 32'h3333_3333;
            raddr1 = 5'd3; raddr2 = 5'd0;
            #2;
            if (busy_a !== 1'b1) break;
            n++;
            if (rdata1_a !== '0 || rdata2_a !== '0 || rdata3_a !== '0 ||
                rdata1_b !== '0 || rdata2_b !== '0 || busy_b !== 1'b1)
                bad = 1'b1;
            @(negedge clock);
        end
        wsign = 1'b0;
        clr   = 1'b0;
        chk({name, " busy_len"}, 32'(n), 32'd32);
        chk({name, " zero_while_busy"}, 32'(bad), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; clr = 1'b0; wsign = 1'b0; waddr = '0; wdata = '0;
        raddr1 = '0; raddr2 = '0;

        // Reset held three edges; outputs blanked even though storage is X
        repeat (3) @(negedge clock);
        chk("reset busy", 32'(busy_a), 32'd1);
        chk("reset rdata1 forced", rdata1_a, 32'd0);
        reset = 1'b0;
        sweep_check(1'b0, "init_sweep");

        for (int i = 0; i < 16; i++)
            apply(mk("init_zero", 1'b0, 1'b0, 5'(i), 32'd0, 5'(i), 5'(i + 16),
                     32'd0, 32'd0, 32'd0, 32'd0));

        // Main table
        tbl.push_back(mk("wr_r5",    1, 0, 5'd5,  32'hDEADBEEF, 5'd5,  5'd31, 0, 0, 0, 0));
        tbl.push_back(mk("wr_r31",   1, 0, 5'd31, 32'h12345678, 5'd5,  5'd31, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF));
        tbl.push_back(mk("rd_r5_31", 0, 0, 5'd5,  32'h0,        5'd5,  5'd31, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'hDEADBEEF));
        tbl.push_back(mk("wr_r0",    1, 0, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd5,  0, 32'hDEADBEEF, 0, 0));
        tbl.push_back(mk("rd_r0",    0, 0, 5'd0,  32'h0,        5'd0,  5'd0,  0, 0, 0, 32'hFFFFFFFF));
        tbl.push_back(mk("wr_r9_1",  1, 0, 5'd9,  32'h00000001, 5'd9,  5'd9,  0, 0, 0, 0));
        tbl.push_back(mk("bypass9",  1, 0, 5'd9,  32'hA5A5A5A5, 5'd9,  5'd5,  32'h1, 32'hDEADBEEF, 32'h1, 32'h1));
        tbl.push_back(mk("rd_r9",    0, 0, 5'd9,  32'h0,        5'd9,  5'd31, 32'hA5A5A5A5, 32'h12345678, 32'hA5A5A5A5, 32'hA5A5A5A5));
        tbl.push_back(mk("wr_r12",   1, 0, 5'd12, 32'hCAFEF00D, 5'd12, 5'd12, 0, 0, 0, 0));
        tbl.push_back(mk("rd_r12",   0, 0, 5'd12, 32'h0,        5'd12, 5'd9,  32'hCAFEF00D, 32'hA5A5A5A5, 32'hCAFEF00D, 32'hCAFEF00D));
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Fill r1..r31 with i*0x01010101, then clr together with a write to r7
        for (int i = 1; i < 32; i++) wr(5'(i), 32'h01010101 * 32'(i));
        apply(mk("fill_rd", 0, 0, 5'd20, 32'h0, 5'd7, 5'd31,
                 32'h07070707, 32'h1F1F1F1F, 32'h14141414, 32'h07070707));
        apply(mk("clr_wr7", 1, 1, 5'd7, 32'hBAD0BAD0, 5'd7, 5'd0,
                 32'h07070707, 32'h0, 32'h07070707, 32'h07070707));
        sweep_check(1'b1, "clr_sweep");
        for (int i = 0; i < 16; i++)
            apply(mk("clr_zero", 1'b0, 1'b0, 5'(i + 16), 32'd0, 5'(i), 5'(i + 16),
                     32'd0, 32'd0, 32'd0, 32'd0));

        // Reset at cnt=10 with writes attempted during the sweep
        wr(5'd3, 32'h00000077);
        apply(mk("clr2", 0, 1, 5'd3, 32'h0, 5'd3, 5'd6, 32'h77, 0, 32'h77, 32'h77));
        @(negedge clock);
        for (int i = 0; i < 10; i++) begin
            wsign = 1'b1; waddr = 5'd3; wdata = 32'h44444444;
            @(negedge clock);
        end
        reset = 1'b1;
        #2;
        chk("midsweep busy", 32'(busy_a), 32'd1);
        @(negedge clock);
        reset = 1'b0;
        sweep_check(1'b0, "restart_sweep");

        apply(mk("post_r3",  0, 0, 5'd3, 32'h0,        5'd3, 5'd3, 0, 0, 0, 0));
        apply(mk("post_wr3", 1, 0, 5'd3, 32'h0BADF00D, 5'd3, 5'd9, 0, 0, 0, 0));
        apply(mk("post_rd3", 0, 0, 5'd3, 32'h0,        5'd3, 5'd0,
                 32'h0BADF00D, 0, 32'h0BADF00D, 32'h0BADF00D));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
